// File: rtl/sram_like_arbiter.sv
// ----------------------------------------------------------------------------
// sram_like_arbiter
//
// Purpose:
//   Shares one SRAM-like memory port between the instruction master (IF stage)
//   and the data master (EXE/MEM stage). A requester is selected every cycle.
//   The selection is held (locked) while a request waits for s_addr_ok.
//   An owner FIFO remembers who issued every accepted transaction, so the
//   in-order s_data_ok responses are routed back to the correct master.
//   Requests and responses pass through with zero latency; no data is buffered.
//
// Parameters:
//   OUTSTANDING   max accepted-but-unanswered transactions (owner FIFO depth, >=1)
//   STARVE_LIMIT  max consecutive data grants while inst_req waits (>=1)
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   inst_req/wr/size/addr/wdata    instruction master request
//   inst_addr_ok/data_ok/rdata     instruction master handshake and response
//   data_req/wr/size/addr/wdata    data master request
//   data_addr_ok/data_ok/rdata     data master handshake and response
//   s_req/wr/size/addr/wdata       request to the slave
//   s_addr_ok/data_ok/rdata        slave handshake and in-order response
//   protocol_err                   sticky: s_data_ok arrived with nothing outstanding
// ----------------------------------------------------------------------------
module sram_like_arbiter #(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic        protocol_err
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] FULL_COUNT = CW'(OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR   = PW'(OUTSTANDING - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  owner_t          sel;
  logic            sel_req;
  owner_t          lock_owner;
  logic            lock_valid;
  logic [SW-1:0]   starve_cnt;
  owner_t          owner_mem [OUTSTANDING];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            not_empty;
  logic            handshake;
  logic            pop;
  owner_t          head_owner;

  // Ring pointer advance; explicit wrap so any depth works, not only powers of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? {PW{1'b0}} : p + {{(PW-1){1'b0}}, 1'b1};
  endfunction

  // Requester selection and slave request field mux.
  always_comb begin
    sel     = OWN_DATA;
    sel_req = 1'b0;
    s_wr    = 1'b0;
    s_size  = 2'b00;
    s_addr  = 32'h0000_0000;
    s_wdata = 32'h0000_0000;
    if (lock_valid) begin
      sel = lock_owner;
    end else if (data_req && !(inst_req && (starve_cnt == STARVE_MAX))) begin
      sel = OWN_DATA;
    end else if (inst_req) begin
      sel = OWN_INST;
    end else begin
      sel = OWN_DATA;
    end
    if (sel == OWN_INST) begin
      sel_req = inst_req;
      s_wr    = inst_wr;
      s_size  = inst_size;
      s_addr  = inst_addr;
      s_wdata = inst_wdata;
    end else begin
      sel_req = data_req;
      s_wr    = data_wr;
      s_size  = data_size;
      s_addr  = data_addr;
      s_wdata = data_wdata;
    end
  end

  // Full is taken from the registered count only, so a same-cycle pop never
  // re-opens the request path (no s_data_ok -> s_req combinational path).
  assign full       = (count == FULL_COUNT);
  assign not_empty  = (count != {CW{1'b0}});
  assign s_req      = !reset && sel_req && !full;
  assign handshake  = s_req && s_addr_ok;
  assign pop        = s_data_ok && not_empty;
  assign head_owner = owner_mem[head_ptr];

  assign inst_addr_ok = handshake && (sel == OWN_INST);
  assign data_addr_ok = handshake && (sel == OWN_DATA);
  assign inst_data_ok = !reset && pop && (head_owner == OWN_INST);
  assign data_data_ok = !reset && pop && (head_owner == OWN_DATA);
  assign inst_rdata   = s_rdata;
  assign data_rdata   = s_rdata;

  // Lock keeps the selection (and thus s_*) stable while the slave stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid <= 1'b0;
      lock_owner <= OWN_INST;
    end else if (handshake) begin
      lock_valid <= 1'b0;
    end else if (s_req) begin
      lock_valid <= 1'b1;
      lock_owner <= sel;
    end
  end

  // Owner FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr <= {PW{1'b0}};
      tail_ptr <= {PW{1'b0}};
      count    <= {CW{1'b0}};
    end else begin
      if (handshake) begin
        tail_ptr <= next_ptr(tail_ptr);
      end
      if (pop) begin
        head_ptr <= next_ptr(head_ptr);
      end
      case ({handshake, pop})
        2'b10:   count <= count + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count <= count - {{(CW-1){1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

  // Owner FIFO storage: record which master issued each accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        owner_mem[i] <= OWN_INST;
      end
    end else if (handshake) begin
      owner_mem[tail_ptr] <= sel;
    end
  end

  // Starvation counter: counts data grants made while inst_req is waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= {SW{1'b0}};
    end else if (!inst_req || (handshake && (sel == OWN_INST))) begin
      starve_cnt <= {SW{1'b0}};
    end else if (handshake && (sel == OWN_DATA) && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + {{(SW-1){1'b0}}, 1'b1};
    end
  end

  // Sticky error: a response with no owner recorded.
  always_ff @(posedge clk) begin
    if (reset) begin
      protocol_err <= 1'b0;
    end else if (s_data_ok && !not_empty) begin
      protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;
  logic        protocol_err;

  int total = 0;
  int bad   = 0;
  // expected owner of each accepted request: 0 = inst, 1 = data
  bit exp_q[$];

  sram_like_arbiter #(.OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle, sample mid-cycle
  task automatic settle();
    #4;
  endtask

  // pop the scoreboard and check routing of the response present this cycle
  task automatic resp_check(input string tag, input logic [31:0] rd);
    bit e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=response expected=scoreboard entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_inst_data_ok"}, {31'd0, inst_data_ok}, {31'd0, !e});
      chk({tag, "_data_data_ok"}, {31'd0, data_data_ok}, {31'd0, e});
      chk({tag, "_inst_rdata"}, inst_rdata, rd);
      chk({tag, "_data_rdata"}, data_rdata, rd);
    end
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0; data_wdata = 32'h0;
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'h0;
    next();

    // reset: everything gated even with all inputs active
    inst_req = 1'b1; data_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1;
    settle();
    chk("rst_s_req", {31'd0, s_req}, 32'd0);
    chk("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("rst_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    chk("rst_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("rst_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    next();
    reset = 1'b0;
    inst_req = 1'b0; data_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
    settle();
    chk("rst_protocol_err", {31'd0, protocol_err}, 32'd0);
    chk("idle_s_req", {31'd0, s_req}, 32'd0);
    next();

    // 1: inst only, two back-to-back accepts, then full until a response
    inst_req = 1'b1; inst_addr = 32'h0000_0100; s_addr_ok = 1'b1;
    settle();
    chk("t1_a_s_req", {31'd0, s_req}, 32'd1);
    chk("t1_a_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t1_a_s_addr", s_addr, 32'h0000_0100);
    exp_q.push_back(1'b0);
    next();
    inst_addr = 32'h0000_0104;
    settle();
    chk("t1_b_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t1_b_s_addr", s_addr, 32'h0000_0104);
    exp_q.push_back(1'b0);
    next();
    inst_addr = 32'h0000_0108;
    settle();
    chk("t1_c_full_s_req", {31'd0, s_req}, 32'd0);
    chk("t1_c_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    next();
    s_data_ok = 1'b1; s_rdata = 32'h1111_1111;
    settle();
    chk("t1_d_full_pop_s_req", {31'd0, s_req}, 32'd0);
    resp_check("t1_d", 32'h1111_1111);
    next();
    inst_req = 1'b0; s_rdata = 32'h2222_2222;
    settle();
    resp_check("t1_e", 32'h2222_2222);
    next();
    s_data_ok = 1'b0;

    // 2: both rise together; data first, then inst; responses in order
    inst_req = 1'b1; inst_addr = 32'h0000_0200;
    data_req = 1'b1; data_addr = 32'h0000_0300;
    settle();
    chk("t2_0_s_addr", s_addr, 32'h0000_0300);
    chk("t2_0_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("t2_0_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    exp_q.push_back(1'b1);
    next();
    data_req = 1'b0;
    settle();
    chk("t2_1_s_addr", s_addr, 32'h0000_0200);
    chk("t2_1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    exp_q.push_back(1'b0);
    next();
    inst_req = 1'b0; s_data_ok = 1'b1; s_rdata = 32'hAAAA_0001;
    settle();
    resp_check("t2_r0", 32'hAAAA_0001);
    next();
    s_rdata = 32'hAAAA_0002;
    settle();
    resp_check("t2_r1", 32'hAAAA_0002);
    next();
    s_data_ok = 1'b0;

    // 3: inst stalls for 3 cycles; lock holds it despite data_req
    inst_req = 1'b1; inst_addr = 32'h0000_0400; s_addr_ok = 1'b0;
    settle();
    chk("t3_0_s_req", {31'd0, s_req}, 32'd1);
    chk("t3_0_s_addr", s_addr, 32'h0000_0400);
    chk("t3_0_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    next();
    data_req = 1'b1; data_addr = 32'h0000_0500; data_wr = 1'b1; data_wdata = 32'hCAFE_F00D;
    settle();
    chk("t3_1_s_addr", s_addr, 32'h0000_0400);
    chk("t3_1_s_wr", {31'd0, s_wr}, 32'd0);
    chk("t3_1_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    next();
    settle();
    chk("t3_2_s_addr", s_addr, 32'h0000_0400);
    next();
    s_addr_ok = 1'b1;
    settle();
    chk("t3_3_s_addr", s_addr, 32'h0000_0400);
    chk("t3_3_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t3_3_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    exp_q.push_back(1'b0);
    next();
    inst_req = 1'b0;
    settle();
    chk("t3_4_s_addr", s_addr, 32'h0000_0500);
    chk("t3_4_s_wr", {31'd0, s_wr}, 32'd1);
    chk("t3_4_s_wdata", s_wdata, 32'hCAFE_F00D);
    chk("t3_4_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    exp_q.push_back(1'b1);
    next();
    data_req = 1'b0; data_wr = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h3333_0001;
    settle();
    resp_check("t3_r0", 32'h3333_0001);
    next();
    s_rdata = 32'h3333_0002;
    settle();
    resp_check("t3_r1_write", 32'h3333_0002);
    next();
    s_data_ok = 1'b0;

    // 4: starvation limit: D,D,D,D,I repeating
    inst_req = 1'b1; inst_addr = 32'h0000_0600;
    data_req = 1'b1; data_addr = 32'h0000_0700;
    s_addr_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_data_ok = (k > 0);
      s_rdata = 32'h4400_0000 + 32'(k);
      settle();
      if (k > 0) resp_check($sformatf("t4_r%0d", k), 32'h4400_0000 + 32'(k));
      chk($sformatf("t4_g%0d_data", k), {31'd0, data_addr_ok}, {31'd0, (k % 5) != 4});
      chk($sformatf("t4_g%0d_inst", k), {31'd0, inst_addr_ok}, {31'd0, (k % 5) == 4});
      exp_q.push_back((k % 5) != 4);
      next();
    end
    inst_req = 1'b0; data_req = 1'b0; s_addr_ok = 1'b0;
    s_data_ok = 1'b1; s_rdata = 32'h4400_00FF;
    settle();
    resp_check("t4_rlast", 32'h4400_00FF);
    next();
    s_data_ok = 1'b0;

    // 5: stray response with nothing outstanding
    s_data_ok = 1'b1; s_rdata = 32'hDEAD_BEEF;
    settle();
    chk("t5_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("t5_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    chk("t5_err_before", {31'd0, protocol_err}, 32'd0);
    next();
    s_data_ok = 1'b0;
    settle();
    chk("t5_err_set", {31'd0, protocol_err}, 32'd1);
    next();
    next();
    settle();
    chk("t5_err_held", {31'd0, protocol_err}, 32'd1);
    next();

    // 6: reset with an outstanding inst and a locked inst request
    inst_req = 1'b1; inst_addr = 32'h0000_0800; s_addr_ok = 1'b1;
    settle();
    chk("t6_a_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    exp_q.push_back(1'b0);
    next();
    inst_addr = 32'h0000_0804; s_addr_ok = 1'b0;
    settle();
    chk("t6_b_stall_s_req", {31'd0, s_req}, 32'd1);
    next();
    reset = 1'b1;
    settle();
    chk("t6_rst_s_req", {31'd0, s_req}, 32'd0);
    chk("t6_rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    exp_q.delete();
    next();
    reset = 1'b0; inst_req = 1'b0;
    data_req = 1'b1; data_addr = 32'h0000_0900; s_addr_ok = 1'b1;
    settle();
    chk("t6_d_err_cleared", {31'd0, protocol_err}, 32'd0);
    chk("t6_d_s_addr", s_addr, 32'h0000_0900);
    chk("t6_d_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    exp_q.push_back(1'b1);
    next();
    data_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h6666_0001;
    settle();
    resp_check("t6_e", 32'h6666_0001);
    next();
    s_rdata = 32'h6666_0002;
    settle();
    chk("t6_f_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("t6_f_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    next();
    s_data_ok = 1'b0;
    settle();
    chk("t6_g_err_set", {31'd0, protocol_err}, 32'd1);
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
